// File: rtl/cpu_pkg.sv
// Shared CPU definitions used by the fetch stage and the decoder.
//
// Contents:
//   MODE_STALL / MODE_NORMAL / MODE_BRANCH - pipeline mode encodings
//   NOP                                    - Thumb NOP halfword used as a bubble
//   fetch_state_t                          - fetch request FSM states
package cpu_pkg;

  localparam logic [1:0]  MODE_STALL  = 2'd0;
  localparam logic [1:0]  MODE_NORMAL = 2'd1;
  localparam logic [1:0]  MODE_BRANCH = 2'd2;

  localparam logic [15:0] NOP = 16'hBF00;

  // IDLE: nothing outstanding, WAIT: request outstanding,
  // DROP: request outstanding whose data is stale and must be discarded
  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DROP
  } fetch_state_t;

endpackage

// File: rtl/fetch_queue.sv
// Four-entry halfword prefetch FIFO for the fetch stage.
//
// Ports:
//   clk, rst   - clock and synchronous active-high reset
//   flush      - empty the queue (branch redirect)
//   push_lo    - write push_data[15:0]
//   push_hi    - write push_data[31:16] (after the low half when both are set)
//   push_data  - 32-bit word returned by instruction memory
//   pop        - remove the head entry
//   count      - number of valid entries (0..4)
//   head       - oldest entry
module fetch_queue (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        push_lo,
  input  logic        push_hi,
  input  logic [31:0] push_data,
  input  logic        pop,
  output logic [2:0]  count,
  output logic [15:0] head
);

  logic [15:0] mem [4];
  logic [1:0]  rd_ptr;
  logic [1:0]  wr_ptr;
  logic [1:0]  hi_ptr;
  logic [1:0]  push_n;
  logic        pop_ok;

  // The upper halfword lands one slot later when the lower one is pushed too
  always_comb begin
    push_n = {1'b0, push_lo} + {1'b0, push_hi};
    hi_ptr = push_lo ? wr_ptr + 2'd1 : wr_ptr;
    pop_ok = pop && (count != 3'd0);
    head   = mem[rd_ptr];
  end

  always_ff @(posedge clk) begin
    if (push_lo) mem[wr_ptr] <= push_data[15:0];
    if (push_hi) mem[hi_ptr] <= push_data[31:16];
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr <= 2'd0;
      wr_ptr <= 2'd0;
      count  <= 3'd0;
    end else begin
      wr_ptr <= wr_ptr + push_n;
      if (pop_ok) rd_ptr <= rd_ptr + 2'd1;
      count  <= count + {1'b0, push_n} - {2'b00, pop_ok};
    end
  end

endmodule

// File: rtl/fetch.sv
// Instruction fetch stage: requests 32-bit words from instruction memory,
// splits them into Thumb halfwords through a 4-entry prefetch queue and
// presents one instruction per cycle to the decoder under mode control.
//
// Ports:
//   clk, rst          - clock and synchronous active-high reset
//   i_mode            - 0 stall, 1 normal, 2 branch, 3 treated as stall
//   i_branch_target   - branch byte address, sampled when i_mode = 2
//   o_imem_req_r      - registered word read request
//   o_imem_addr_r     - registered word-aligned request address
//   i_imem_ack        - read data valid, only honoured while requesting
//   i_imem_rdata      - read word (addr+0 in [15:0], addr+2 in [31:16])
//   o_ir_r            - instruction to the decoder
//   o_ir_valid_r      - o_ir_r is a real instruction, not a bubble
//   o_pc_r            - byte address of o_ir_r
module fetch
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  i_mode,
  input  logic [31:0] i_branch_target,
  output logic        o_imem_req_r,
  output logic [31:0] o_imem_addr_r,
  input  logic        i_imem_ack,
  input  logic [31:0] i_imem_rdata,
  output logic [15:0] o_ir_r,
  output logic        o_ir_valid_r,
  output logic [31:0] o_pc_r
);

  fetch_state_t state, state_next;

  logic [31:0] fetch_addr;
  logic [31:0] head_pc;
  logic        skip;

  logic        branch;
  logic        normal;
  logic        ack;
  logic        pop;
  logic        push_lo;
  logic        push_hi;
  logic        issue;
  logic [31:0] branch_fetch;
  logic [31:0] branch_pc;
  logic [2:0]  q_count;
  logic [2:0]  count_after_pop;
  logic [15:0] q_head;

  logic        req_next;
  logic [31:0] addr_next;
  logic [15:0] ir_next;
  logic        valid_next;
  logic [31:0] pc_next;

  fetch_queue u_queue (
    .clk       (clk),
    .rst       (rst),
    .flush     (branch),
    .push_lo   (push_lo),
    .push_hi   (push_hi),
    .push_data (i_imem_rdata),
    .pop       (pop),
    .count     (q_count),
    .head      (q_head)
  );

  // Data is only accepted in WAIT without a simultaneous branch; the
  // low halfword is skipped when the branch target was the upper half
  always_comb begin
    branch          = (i_mode == MODE_BRANCH);
    normal          = (i_mode == MODE_NORMAL);
    ack             = i_imem_ack && o_imem_req_r;
    pop             = normal && (q_count != 3'd0);
    count_after_pop = q_count - {2'b00, pop};
    push_hi         = (state == WAIT) && ack && !branch;
    push_lo         = push_hi && !skip;
    branch_fetch    = i_branch_target & 32'hFFFF_FFFC;
    branch_pc       = i_branch_target & 32'hFFFF_FFFE;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // A branch seen in IDLE issues straight to the target since the queue is
  // flushed in the same cycle; a branch in WAIT poisons the outstanding word
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (branch || (count_after_pop <= 3'd2)) state_next = WAIT;
      WAIT:    if (ack) state_next = IDLE;
               else if (branch) state_next = DROP;
      DROP:    if (ack) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    issue      = (state == IDLE) && (state_next == WAIT);
    req_next   = (state_next != IDLE);
    addr_next  = o_imem_addr_r;
    if (issue) addr_next = branch ? branch_fetch : fetch_addr;

    ir_next    = o_ir_r;
    valid_next = o_ir_valid_r;
    pc_next    = o_pc_r;
    if (branch) begin
      ir_next    = NOP;
      valid_next = 1'b0;
      pc_next    = branch_pc;
    end else if (normal) begin
      if (pop) begin
        ir_next    = q_head;
        valid_next = 1'b1;
        pc_next    = head_pc;
      end else begin
        ir_next    = NOP;
        valid_next = 1'b0;
      end
    end
  end

  // head_pc follows the queue head so o_pc_r can be loaded on each pop
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_addr    <= RESET_PC;
      head_pc       <= RESET_PC;
      skip          <= 1'b0;
      o_imem_req_r  <= 1'b0;
      o_imem_addr_r <= RESET_PC;
      o_ir_r        <= NOP;
      o_ir_valid_r  <= 1'b0;
      o_pc_r        <= RESET_PC;
    end else begin
      o_imem_req_r  <= req_next;
      o_imem_addr_r <= addr_next;
      o_ir_r        <= ir_next;
      o_ir_valid_r  <= valid_next;
      o_pc_r        <= pc_next;
      if (branch) begin
        fetch_addr <= branch_fetch;
        head_pc    <= branch_pc;
        skip       <= i_branch_target[1];
      end else begin
        if (push_hi) begin
          fetch_addr <= fetch_addr + 32'd4;
          skip       <= 1'b0;
        end
        if (pop) head_pc <= head_pc + 32'd2;
      end
    end
  end

endmodule

// File: tb/tb_fetch.sv
// Directed self-checking bench for the fetch stage. A small memory model
// answers requests with a programmable latency; word at address A holds
// halfwords equal to their own low address bits, except address 0 which
// holds 32'h2105_2003.
module tb_fetch;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  i_mode;
  logic [31:0] i_branch_target;
  logic        o_imem_req_r;
  logic [31:0] o_imem_addr_r;
  logic        i_imem_ack;
  logic [31:0] i_imem_rdata;
  logic [15:0] o_ir_r;
  logic        o_ir_valid_r;
  logic [31:0] o_pc_r;

  int checks   = 0;
  int failures = 0;
  bit memAuto;
  int ackDelay;
  int waitCnt;
  int ackCount;

  always #5 clk = ~clk;

  fetch #(.RESET_PC(32'h0000_0000)) dut (
    .clk             (clk),
    .rst             (rst),
    .i_mode          (i_mode),
    .i_branch_target (i_branch_target),
    .o_imem_req_r    (o_imem_req_r),
    .o_imem_addr_r   (o_imem_addr_r),
    .i_imem_ack      (i_imem_ack),
    .i_imem_rdata    (i_imem_rdata),
    .o_ir_r          (o_ir_r),
    .o_ir_valid_r    (o_ir_valid_r),
    .o_pc_r          (o_pc_r)
  );

  function automatic logic [31:0] memWord(input logic [31:0] a);
    if (a == 32'h0) return 32'h2105_2003;
    return {a[15:0] + 16'd2, a[15:0]};
  endfunction

  // Memory model: answers shortly after each rising edge so the DUT sees a
  // stable ack at the next edge
  always @(posedge clk) begin
    #2;
    if (memAuto) begin
      if (o_imem_req_r) begin
        if (waitCnt >= ackDelay) begin
          i_imem_ack   = 1'b1;
          i_imem_rdata = memWord(o_imem_addr_r);
          waitCnt      = 0;
          ackCount     = ackCount + 1;
        end else begin
          i_imem_ack = 1'b0;
          waitCnt    = waitCnt + 1;
        end
      end else begin
        i_imem_ack = 1'b0;
        waitCnt    = 0;
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks = checks + 1;
    if (actual !== expected) begin
      failures = failures + 1;
      $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] mode, input logic [31:0] target);
    i_mode          = mode;
    i_branch_target = target;
  endtask

  task automatic checkReset(input string tag);
    checkOutput({tag, "_req"},   32'(o_imem_req_r),  32'd0);
    checkOutput({tag, "_addr"},  o_imem_addr_r,      32'h0);
    checkOutput({tag, "_ir"},    32'(o_ir_r),        32'h0000_BF00);
    checkOutput({tag, "_valid"}, 32'(o_ir_valid_r),  32'd0);
    checkOutput({tag, "_pc"},    o_pc_r,             32'h0);
  endtask

  // Release reset at a falling edge and follow the first word through
  task automatic bootSequence(input string tag);
    rst        = 1'b0;
    i_imem_ack = 1'b0;
    ackCount   = 0;
    waitCnt    = 0;
    ackDelay   = 0;
    memAuto    = 1'b1;
    applyStimulus(MODE_NORMAL, 32'h0);
    @(negedge clk);
    checkOutput({tag, "_first_req"},  32'(o_imem_req_r), 32'd1);
    checkOutput({tag, "_first_addr"}, o_imem_addr_r,     32'h0);
    @(negedge clk);
    checkOutput({tag, "_bubble"},     32'(o_ir_valid_r), 32'd0);
    @(negedge clk);
    checkOutput({tag, "_ir0"},        32'(o_ir_r),       32'h2003);
    checkOutput({tag, "_pc0"},        o_pc_r,            32'h0);
    checkOutput({tag, "_valid0"},     32'(o_ir_valid_r), 32'd1);
  endtask

  task automatic waitValid(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (o_ir_valid_r) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit          ok;
    bit          prevReq;
    logic [15:0] expIr [5];
    logic [31:0] expPc [5];

    rst          = 1'b1;
    memAuto      = 1'b1;
    ackDelay     = 0;
    waitCnt      = 0;
    ackCount     = 0;
    i_imem_ack   = 1'b0;
    i_imem_rdata = 32'h0;
    applyStimulus(MODE_NORMAL, 32'h0);
    repeat (2) @(negedge clk);
    $display("[TB] reset values");
    checkReset("rst0");

    $display("[TB] first fetch from reset PC");
    bootSequence("boot");

    $display("[TB] stall for 10 cycles");
    for (int i = 0; i < 10; i++) begin
      applyStimulus((i < 5) ? MODE_STALL : 2'd3, 32'h0);
      @(negedge clk);
      checkOutput("stall_ir",  32'(o_ir_r),       32'h2003);
      checkOutput("stall_req", 32'(o_imem_req_r), 32'd0);
    end
    checkOutput("stall_pc",     o_pc_r,            32'h0);
    checkOutput("stall_valid",  32'(o_ir_valid_r), 32'd1);
    checkOutput("stall_words",  32'(ackCount),     32'd2);

    $display("[TB] resume normal flow");
    expIr = '{16'h2105, 16'h0004, 16'h0006, 16'h0008, 16'h000A};
    expPc = '{32'h2, 32'h4, 32'h6, 32'h8, 32'hA};
    applyStimulus(MODE_NORMAL, 32'h0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checkOutput("resume_ir",    32'(o_ir_r),       32'(expIr[k]));
      checkOutput("resume_pc",    o_pc_r,            expPc[k]);
      checkOutput("resume_valid", 32'(o_ir_valid_r), 32'd1);
    end

    $display("[TB] branch during slow request");
    ackDelay = 3;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (o_imem_req_r && !i_imem_ack) begin
        ok = 1'b1;
        break;
      end
    end
    checkOutput("drop_req_seen", 32'(ok), 32'd1);
    applyStimulus(MODE_BRANCH, 32'h0000_0102);
    @(negedge clk);
    applyStimulus(MODE_NORMAL, 32'h0);
    checkOutput("drop_valid", 32'(o_ir_valid_r), 32'd0);
    checkOutput("drop_ir",    32'(o_ir_r),       32'h0000_BF00);
    checkOutput("drop_pc",    o_pc_r,            32'h0000_0102);
    checkOutput("drop_req",   32'(o_imem_req_r), 32'd1);
    prevReq = o_imem_req_r;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (o_imem_req_r && !prevReq) begin
        ok = 1'b1;
        break;
      end
      prevReq = o_imem_req_r;
    end
    checkOutput("drop_reissue", 32'(ok),       32'd1);
    checkOutput("drop_addr",    o_imem_addr_r, 32'h0000_0100);
    waitValid(ok);
    checkOutput("target_valid", 32'(ok),     32'd1);
    checkOutput("target_pc",    o_pc_r,      32'h0000_0102);
    checkOutput("target_ir",    32'(o_ir_r), 32'h0102);
    waitValid(ok);
    checkOutput("next_valid",   32'(ok),     32'd1);
    checkOutput("next_pc",      o_pc_r,      32'h0000_0104);
    checkOutput("next_ir",      32'(o_ir_r), 32'h0104);

    $display("[TB] ack and branch together");
    memAuto    = 1'b0;
    i_imem_ack = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (o_imem_req_r) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    checkOutput("ab_req_seen", 32'(ok), 32'd1);
    i_imem_ack   = 1'b1;
    i_imem_rdata = 32'hDEAD_BEEF;
    applyStimulus(MODE_BRANCH, 32'h0000_0200);
    @(negedge clk);
    i_imem_ack = 1'b0;
    applyStimulus(MODE_NORMAL, 32'h0);
    checkOutput("ab_req_low", 32'(o_imem_req_r), 32'd0);
    checkOutput("ab_valid",   32'(o_ir_valid_r), 32'd0);
    checkOutput("ab_ir",      32'(o_ir_r),       32'h0000_BF00);
    checkOutput("ab_pc",      o_pc_r,            32'h0000_0200);
    @(negedge clk);
    checkOutput("ab_req",     32'(o_imem_req_r), 32'd1);
    checkOutput("ab_addr",    o_imem_addr_r,     32'h0000_0200);
    i_imem_ack   = 1'b1;
    i_imem_rdata = 32'h4444_3333;
    @(negedge clk);
    i_imem_ack = 1'b0;
    checkOutput("ab_wait_valid", 32'(o_ir_valid_r), 32'd0);
    @(negedge clk);
    checkOutput("ab_ir0",    32'(o_ir_r),       32'h3333);
    checkOutput("ab_pc0",    o_pc_r,            32'h0000_0200);
    checkOutput("ab_valid0", 32'(o_ir_valid_r), 32'd1);
    checkOutput("ab_req2",   32'(o_imem_req_r), 32'd1);
    checkOutput("ab_addr2",  o_imem_addr_r,     32'h0000_0204);

    $display("[TB] reset with request outstanding");
    @(negedge clk);
    checkOutput("ab_ir1",      32'(o_ir_r),       32'h4444);
    checkOutput("ab_pc1",      o_pc_r,            32'h0000_0202);
    checkOutput("pre_rst_req", 32'(o_imem_req_r), 32'd1);
    rst          = 1'b1;
    i_imem_ack   = 1'b1;
    i_imem_rdata = 32'h7777_6666;
    repeat (2) @(negedge clk);
    checkReset("rst1");
    bootSequence("reboot");

    $display("[TB] address wrap");
    applyStimulus(MODE_STALL, 32'h0);
    repeat (8) @(negedge clk);
    checkOutput("wrap_quiet", 32'(o_imem_req_r), 32'd0);
    applyStimulus(MODE_BRANCH, 32'hFFFF_FFFC);
    @(negedge clk);
    applyStimulus(MODE_NORMAL, 32'h0);
    checkOutput("wrap_req",   32'(o_imem_req_r), 32'd1);
    checkOutput("wrap_addr",  o_imem_addr_r,     32'hFFFF_FFFC);
    checkOutput("wrap_pc_br", o_pc_r,            32'hFFFF_FFFC);
    @(negedge clk);
    @(negedge clk);
    checkOutput("wrap_ir0",   32'(o_ir_r),       32'hFFFC);
    checkOutput("wrap_pc0",   o_pc_r,            32'hFFFF_FFFC);
    checkOutput("wrap_next",  o_imem_addr_r,     32'h0000_0000);
    checkOutput("wrap_nreq",  32'(o_imem_req_r), 32'd1);
    @(negedge clk);
    checkOutput("wrap_ir1",   32'(o_ir_r),       32'hFFFE);
    checkOutput("wrap_pc1",   o_pc_r,            32'hFFFF_FFFE);
    @(negedge clk);
    checkOutput("wrap_ir2",   32'(o_ir_r),       32'h2003);
    checkOutput("wrap_pc2",   o_pc_r,            32'h0000_0000);
    checkOutput("wrap_valid", 32'(o_ir_valid_r), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
